game_state_rx: RTL
==================

Name: game_state_rx

Overview:
- RMII-side receiver and decoder for the opponent game-state frame. It is the far end of the frame that `transmit` builds on the other board.
- Takes raw RMII dibits at the 50 MHz `eth_refclk` and strips the preamble/SFD.
- Filters the frame on destination MAC and EtherType, checks the FCS, and extracts opponent x/y/direction/status.
- Fields are committed only on a clean frame. Its outputs drive the `opponent_x` / `opponent_y` inputs of `track_view`, `racer_view` and `forward_view`.

Parameters:
- `MY_MAC`, `48'h02_00_00_00_00_02`: accepted unicast destination; `48'hFF_FF_FF_FF_FF_FF` is also accepted.
- `ETHERTYPE`, `16'h88B5`: required EtherType.
- `MAX_BYTES`, `1522`: byte limit after SFD; exceeding it drops the frame.

Ports:
- `eth_clk` in 1: 50 MHz RMII reference clock, sole clock.
- `eth_rst_n` in 1: synchronous active-low reset.
- `eth_crsdv` in 1: RMII carrier-sense/data-valid.
- `eth_rxd` in 2: RMII receive dibit.
- `opp_x` out 11: last good opponent x.
- `opp_y` out 11: last good opponent y.
- `opp_dir` out 9: last good direction, 0..359.
- `opp_stat` out 2: last good game status.
- `frame_valid` out 1: 1-cycle pulse when the outputs update.
- `frame_err` out 1: 1-cycle pulse when a frame is dropped (CRC, runt, misalignment, oversize).

Behaviour:
- **Reset** (`eth_rst_n` = 0 at posedge):
  - State goes to IDLE.
  - `opp_x`/`opp_y`/`opp_dir`/`opp_stat`/`frame_valid`/`frame_err` = 0.
  - Shadow registers, CRC register and counters are cleared.
  - Reset mid-frame abandons the frame with no pulse. After reset, IDLE waits for `eth_crsdv` low before it can hunt for a new frame.
- **Bit order:**
  - Dibits arrive LSB first; four dibits form one byte: byte = {d3,d2,d1,d0}.
  - Multi-byte fields are big-endian on the wire.
- **Frame layout after SFD:**
  - dst[6], src[6], type[2]
  - payload: {5'b0,x}[2], {5'b0,y}[2], {7'b0,dir}[2], {6'b0,stat}[1]
  - pad to 46 payload bytes, then FCS[4]
- **States:** IDLE, PREAMBLE, DEST, SRC, TYPE, PAYLOAD, PAD, CHECK, DROP.
  - IDLE → PREAMBLE when `eth_crsdv`=1 and `eth_rxd`=2'b01.
  - PREAMBLE:
    - Stays while dibit = 01.
    - On dibit 11 (SFD tail), go to DEST with the dibit counter = 0.
    - Any other dibit, or `eth_crsdv`=0, → IDLE silently.
  - DEST: 6 bytes. On mismatch with both `MY_MAC` and broadcast → DROP (silent, no `frame_err`).
  - SRC: skips 6 bytes.
  - TYPE: 2 bytes; mismatch with `ETHERTYPE` → DROP (silent).
  - PAYLOAD: 7 bytes captured into shadow registers, then PAD.
  - PAD: consumes bytes until `eth_crsdv` samples 0, then → CHECK.
  - `eth_crsdv` sampled 0 in DEST/SRC/TYPE/PAYLOAD (runt) → `frame_err`, IDLE.
  - DROP: waits for `eth_crsdv`=0, then IDLE.
- **CRC:**
  - CRC-32 (reflected poly `0xEDB88320`, init `0xFFFFFFFF`), updated 2 bits/cycle over every dibit from the first DEST dibit through the FCS.
  - The CRC only updates on cycles with `eth_crsdv`=1.
  - In CHECK, the frame is good iff the CRC register equals the residue `0xDEBB20E3` (non-inverted register form).
- **End alignment:** `eth_crsdv` falling with the dibit counter ≠ 0 mod 4 is an alignment error → `frame_err`.
- **Total length:**
  - A frame is a runt (`frame_err`) if total bytes after SFD < 64.
  - If it exceeds `MAX_BYTES`, assert `frame_err` immediately and go to DROP.
- **Latency:** `eth_crsdv` sampled 0 at edge N → CHECK at N → outputs updated, and `frame_valid` or `frame_err` high, in the cycle after edge N+1. Exactly one of the two pulses per checked frame.
- **Hold behaviour:** outputs hold their last good values indefinitely; a bad or dropped frame never alters them.
- **Range:** `opp_dir` > 359 in a CRC-good frame is treated as an error: `frame_err`, no update.
- **Back-to-back frames:** CHECK → IDLE unconditionally. A new preamble starting on the cycle after CHECK must be accepted, and the inter-frame gap may be as short as 12 bytes.

Test Plan:
- **Good unicast frame:** dst=`MY_MAC`, type `88B5`, x=191, y=191, dir=270, stat=1, correct FCS → `frame_valid` pulse 2 cycles after `eth_crsdv` falls; `opp_x`=191, `opp_y`=191, `opp_dir`=270, `opp_stat`=1.
- **Corrupted FCS:** a good frame (x=319) followed by the same frame with FCS bit 0 flipped (x=500) → `frame_err` pulse; outputs stay 319; no `frame_valid`.
- **Filtered frames:** dst=`02:00:00:00:00:05` or type `0800` → neither pulse; outputs unchanged. Broadcast dst with x=10 → `frame_valid`, `opp_x`=10.
- **Runt and misalignment:** runt (`eth_crsdv` drops after 3 payload bytes) → `frame_err`. A 65th-byte partial (`eth_crsdv` drops after 2 dibits) → `frame_err`. Oversize 1600-byte frame → `frame_err` at byte 1523; subsequent good frame decodes.
- **Back-to-back:** two good frames (x=1, then x=2) with a 12-byte gap → two `frame_valid` pulses; final `opp_x`=2.
- **Reset mid-PAYLOAD:** after a good frame (x=50), drive `eth_rst_n`=0 for 1 cycle during PAYLOAD → all outputs 0, no pulse for the interrupted frame; the next good frame (x=77) is decoded normally.

Source files
------------

// File: rtl/game_state_rx.sv
`default_nettype none
// ============================================================================
//  Module   : game_state_rx
//  Purpose  : RMII receiver/decoder for the opponent game-state frame.
//             Strips preamble/SFD, filters on destination MAC and EtherType,
//             checks the FCS and commits opponent x/y/dir/status only on a
//             clean frame.
//  Revision : 1.0 - initial release
// ============================================================================
module game_state_rx #(
    parameter logic [47:0] MY_MAC    = 48'h02_00_00_00_00_02,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          MAX_BYTES = 1522
) (
    input  logic        eth_clk,
    input  logic        eth_rst_n,
    input  logic        eth_crsdv,
    input  logic [1:0]  eth_rxd,
    output logic [10:0] opp_x,
    output logic [10:0] opp_y,
    output logic [8:0]  opp_dir,
    output logic [1:0]  opp_stat,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int CW = $clog2(4 * MAX_BYTES + 1);
    localparam int BW = CW - 2;

    localparam logic [CW-1:0] c_MAX_DIBITS = CW'(4 * MAX_BYTES);
    localparam logic [CW-1:0] c_MIN_DIBITS = CW'(4 * 64);
    localparam logic [31:0]   c_POLY       = 32'hEDB8_8320;
    localparam logic [31:0]   c_RESIDUE    = 32'hDEBB_20E3;

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_PREAMBLE = 4'd1;
    localparam logic [3:0] c_DEST     = 4'd2;
    localparam logic [3:0] c_SRC      = 4'd3;
    localparam logic [3:0] c_TYPE     = 4'd4;
    localparam logic [3:0] c_PAYLOAD  = 4'd5;
    localparam logic [3:0] c_PAD      = 4'd6;
    localparam logic [3:0] c_CHECK    = 4'd7;
    localparam logic [3:0] c_DROP     = 4'd8;

    logic [3:0]    r_state;
    logic          r_wait_low;   // set by reset: ignore the tail of any frame in flight
    logic [CW-1:0] r_dcnt;       // dibits received since SFD
    logic [5:0]    r_sh;         // first three dibits of the current byte
    logic [31:0]   r_crc;
    logic          r_dst_me;
    logic          r_dst_bc;
    logic [7:0]    r_type_hi;
    logic [10:0]   r_x;
    logic [10:0]   r_y;
    logic [8:0]    r_dir;
    logic [1:0]    r_stat;

    logic [7:0]    w_byte;
    logic          w_last;
    logic [BW-1:0] w_bidx;
    logic [31:0]   w_crc_next;
    logic [7:0]    w_me_byte;
    logic          w_me_ok;
    logic          w_bc_ok;

    // Reflected CRC-32, two bits per call, bit 0 of the dibit first.
    function automatic logic [31:0] f_crc_dibit(input logic [31:0] crc, input logic [1:0] dib);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ dib[i]) c = (c >> 1) ^ c_POLY;
            else               c = c >> 1;
        end
        return c;
    endfunction

    assign w_byte     = {eth_rxd, r_sh};
    assign w_last     = (r_dcnt[1:0] == 2'b11);
    assign w_bidx     = r_dcnt[CW-1:2];
    assign w_crc_next = f_crc_dibit(r_crc, eth_rxd);
    assign w_me_ok    = r_dst_me && (w_byte == w_me_byte);
    assign w_bc_ok    = r_dst_bc && (w_byte == 8'hFF);

    // Pick the MY_MAC byte expected at the current destination byte position.
    always_comb begin
        w_me_byte = MY_MAC[47:40];
        case (w_bidx[2:0])
            3'd1:    w_me_byte = MY_MAC[39:32];
            3'd2:    w_me_byte = MY_MAC[31:24];
            3'd3:    w_me_byte = MY_MAC[23:16];
            3'd4:    w_me_byte = MY_MAC[15:8];
            3'd5:    w_me_byte = MY_MAC[7:0];
            default: ;
        endcase
    end

    // Frame FSM: field walking, CRC accumulation, field capture and commit.
    always_ff @(posedge eth_clk) begin
        if (!eth_rst_n) begin
            r_state     <= c_IDLE;
            r_wait_low  <= 1'b1;
            r_dcnt      <= '0;
            r_sh        <= '0;
            r_crc       <= '0;
            r_dst_me    <= 1'b0;
            r_dst_bc    <= 1'b0;
            r_type_hi   <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_dir       <= '0;
            r_stat      <= '0;
            opp_x       <= '0;
            opp_y       <= '0;
            opp_dir     <= '0;
            opp_stat    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (r_wait_low) begin
                        if (!eth_crsdv) r_wait_low <= 1'b0;
                    end else if (eth_crsdv && eth_rxd == 2'b01) begin
                        r_state <= c_PREAMBLE;
                    end
                end
                c_PREAMBLE: begin
                    if (!eth_crsdv) begin
                        r_state <= c_IDLE;
                    end else if (eth_rxd == 2'b11) begin
                        r_state  <= c_DEST;
                        r_dcnt   <= '0;
                        r_crc    <= 32'hFFFF_FFFF;
                        r_dst_me <= 1'b1;
                        r_dst_bc <= 1'b1;
                    end else if (eth_rxd != 2'b01) begin
                        r_state <= c_IDLE;
                    end
                end
                c_DEST, c_SRC, c_TYPE, c_PAYLOAD: begin
                    if (!eth_crsdv) begin
                        // Carrier lost before the payload was complete: runt.
                        frame_err <= 1'b1;
                        r_state   <= c_IDLE;
                    end else begin
                        r_dcnt <= r_dcnt + CW'(1);
                        r_crc  <= w_crc_next;
                        r_sh   <= {eth_rxd, r_sh[5:2]};
                        if (w_last) begin
                            if (r_state == c_DEST) begin
                                r_dst_me <= w_me_ok;
                                r_dst_bc <= w_bc_ok;
                                if (w_bidx == BW'(5))
                                    r_state <= (w_me_ok || w_bc_ok) ? c_SRC : c_DROP;
                            end else if (r_state == c_SRC) begin
                                if (w_bidx == BW'(11)) r_state <= c_TYPE;
                            end else if (r_state == c_TYPE) begin
                                r_type_hi <= w_byte;
                                if (w_bidx == BW'(13))
                                    r_state <= ({r_type_hi, w_byte} == ETHERTYPE) ? c_PAYLOAD : c_DROP;
                            end else begin
                                case (w_bidx)
                                    BW'(14): r_x[10:8]  <= w_byte[2:0];
                                    BW'(15): r_x[7:0]   <= w_byte;
                                    BW'(16): r_y[10:8]  <= w_byte[2:0];
                                    BW'(17): r_y[7:0]   <= w_byte;
                                    BW'(18): r_dir[8]   <= w_byte[0];
                                    BW'(19): r_dir[7:0] <= w_byte;
                                    BW'(20): begin
                                        r_stat  <= w_byte[1:0];
                                        r_state <= c_PAD;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                c_PAD: begin
                    if (!eth_crsdv) begin
                        r_state <= c_CHECK;
                    end else if (r_dcnt == c_MAX_DIBITS) begin
                        // First dibit beyond the byte limit: drop right away.
                        frame_err <= 1'b1;
                        r_state   <= c_DROP;
                    end else begin
                        r_dcnt <= r_dcnt + CW'(1);
                        r_crc  <= w_crc_next;
                    end
                end
                c_CHECK: begin
                    if (r_crc == c_RESIDUE && r_dcnt >= c_MIN_DIBITS &&
                        r_dcnt[1:0] == 2'b00 && r_dir <= 9'd359) begin
                        opp_x       <= r_x;
                        opp_y       <= r_y;
                        opp_dir     <= r_dir;
                        opp_stat    <= r_stat;
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    r_state <= c_IDLE;
                end
                c_DROP: begin
                    if (!eth_crsdv) r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
